// File: rtl/cxd2545_soct_ctrl_pkg.sv
// Shared definitions for the CXD2545 SOCT status-readout controller:
// FSM states, command framing constants and status-word field layout.
package cxd2545_soct_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } soct_state_t;

  localparam int CMD_BITS = 24;
  localparam int CMD_LEN_SHORT = 8;
  localparam int CMD_LEN_MID   = 16;
  localparam int CMD_LEN_LONG  = 24;

  // Mode-specification register; carries the SOCT-enable bit
  localparam logic [3:0] ADDR_MODE_SPEC = 4'h8;

  localparam int STATUS_BITS = 18;
  localparam int SW_PER_LSB  = 10;
  localparam int SW_C1_LSB   = 7;
  localparam int SW_C2_LSB   = 4;
  localparam int SW_FOK      = 3;
  localparam int SW_GFS      = 2;
  localparam int SW_LOCK     = 1;
  localparam int SW_EMPH     = 0;

  // PER is stored bit-reversed so the shifter emits its LSB first
  function automatic logic [STATUS_BITS-1:0] pack_status(
    input logic [7:0] per,
    input logic [2:0] c1,
    input logic [2:0] c2,
    input logic       fok,
    input logic       gfs,
    input logic       lock,
    input logic       emph
  );
    logic [STATUS_BITS-1:0] word;
    logic [7:0]             per_rev;
    for (int i = 0; i < 8; i++) per_rev[i] = per[7-i];
    word                    = '0;
    word[SW_PER_LSB +: 8]   = per_rev;
    word[SW_C1_LSB +: 3]    = c1;
    word[SW_C2_LSB +: 3]    = c2;
    word[SW_FOK]            = fok;
    word[SW_GFS]            = gfs;
    word[SW_LOCK]           = lock;
    word[SW_EMPH]           = emph;
    return word;
  endfunction

endpackage

// File: rtl/cxd2545_sync_edge.sv
// Two-flop synchroniser for an asynchronous host line, with a third stage
// used to produce registered one-clock rise and fall pulses.
module cxd2545_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  // Reset to the line's idle level so leaving reset does not fake an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{IDLE_LEVEL}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din};
      rise   <= sync_q[1] & ~sync_q[2];
      fall   <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level = sync_q[2];

endmodule

// File: rtl/cxd2545_soct_ctrl.sv
// CXD2545 SOCT readout sequencer: host command deserialiser, SOCT-enable
// tracking, frame-coherent status snapshot and sqck readout supervision.
module cxd2545_soct_ctrl
  import cxd2545_soct_ctrl_pkg::*;
#(
  parameter logic [3:0] SOCT_ADDR = ADDR_MODE_SPEC,
  parameter int         SOCT_BIT  = 1,
  parameter int         RD_BITS   = 18,
  parameter int         TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_in,
  input  logic        data_in,
  input  logic        xlat_in,
  input  logic        sqck_in,
  input  logic        frame_stb,
  input  logic [7:0]  per_in,
  input  logic [2:0]  c1_in,
  input  logic [2:0]  c2_in,
  input  logic        fok_in,
  input  logic        gfs_in,
  input  logic        lock_in,
  input  logic        emph_in,
  output logic [17:0] status_word,
  output logic        soct_load,
  output logic        soct_en,
  output logic        busy,
  output logic        cmd_valid,
  output logic [3:0]  cmd_addr,
  output logic [19:0] cmd_data,
  output logic        rd_timeout
);

  localparam int BC_W = $clog2(CMD_BITS + 1);
  localparam int RC_W = $clog2(RD_BITS + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0] LEN_SHORT = BC_W'(CMD_LEN_SHORT);
  localparam logic [BC_W-1:0] LEN_MID   = BC_W'(CMD_LEN_MID);
  localparam logic [BC_W-1:0] LEN_LONG  = BC_W'(CMD_LEN_LONG);
  localparam logic [BC_W-1:0] LEN_MAX   = BC_W'(CMD_BITS);

  logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
  logic data_lvl, data_rise_unused, data_fall_unused;
  logic xlat_fall, xlat_lvl_unused, xlat_rise_unused;
  logic sqck_fall, sqck_lvl_unused, sqck_rise_unused;

  cxd2545_sync_edge #(.IDLE_LEVEL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk_in),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );
  cxd2545_sync_edge #(.IDLE_LEVEL(1'b0)) u_data_sync (
    .clk(clk), .rst(rst), .din(data_in),
    .level(data_lvl), .rise(data_rise_unused), .fall(data_fall_unused)
  );
  cxd2545_sync_edge #(.IDLE_LEVEL(1'b0)) u_xlat_sync (
    .clk(clk), .rst(rst), .din(xlat_in),
    .level(xlat_lvl_unused), .rise(xlat_rise_unused), .fall(xlat_fall)
  );
  cxd2545_sync_edge #(.IDLE_LEVEL(1'b1)) u_sqck_sync (
    .clk(clk), .rst(rst), .din(sqck_in),
    .level(sqck_lvl_unused), .rise(sqck_rise_unused), .fall(sqck_fall)
  );

  logic [CMD_BITS-1:0] cmd_sr;
  logic [BC_W-1:0]     bit_cnt;
  logic                word_ok;
  logic [3:0]          dec_addr;
  logic [19:0]         dec_data;
  logic [3:0]          dec_nib;
  logic                cmd_accept;
  logic                soct_en_nxt;

  // The address is always the first nibble received, so its position depends on length
  always_comb begin
    word_ok  = 1'b1;
    dec_addr = '0;
    dec_data = '0;
    dec_nib  = '0;
    case (bit_cnt)
      LEN_SHORT: begin
        dec_addr = cmd_sr[7:4];
        dec_data = {16'b0, cmd_sr[3:0]};
        dec_nib  = cmd_sr[3:0];
      end
      LEN_MID: begin
        dec_addr = cmd_sr[15:12];
        dec_data = {8'b0, cmd_sr[11:0]};
        dec_nib  = cmd_sr[11:8];
      end
      LEN_LONG: begin
        dec_addr = cmd_sr[23:20];
        dec_data = cmd_sr[19:0];
        dec_nib  = cmd_sr[19:16];
      end
      default: word_ok = 1'b0;
    endcase
  end

  assign cmd_accept  = xlat_fall & word_ok;
  assign soct_en_nxt = (cmd_accept && dec_addr == SOCT_ADDR) ? dec_nib[SOCT_BIT] : soct_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_sr    <= '0;
      bit_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      soct_en   <= 1'b0;
    end else begin
      cmd_valid <= cmd_accept;
      soct_en   <= soct_en_nxt;
      if (cmd_accept) begin
        cmd_addr <= dec_addr;
        cmd_data <= dec_data;
      end
      if (xlat_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && bit_cnt != LEN_MAX) begin
        cmd_sr  <= {cmd_sr[CMD_BITS-2:0], data_lvl};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  soct_state_t     state, state_nxt;
  logic [RC_W-1:0] rd_cnt;
  logic [TM_W-1:0] tmr;
  logic            restart, rd_done, rd_expired;

  assign restart    = xlat_fall & soct_en_nxt;
  assign rd_done    = (rd_cnt == RC_W'(RD_BITS));
  assign rd_expired = (tmr == TM_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (restart) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (restart)                    state_nxt = ST_LOAD;
        else if (rd_done || rd_expired) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    soct_load  = (state == ST_LOAD);
    busy       = (state == ST_SHIFT);
    rd_timeout = (state == ST_SHIFT) && !restart && !rd_done && rd_expired;
  end

  // Counters only live while we stay in SHIFT; any exit or restart clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      tmr    <= '0;
    end else if (state != ST_SHIFT || state_nxt != ST_SHIFT) begin
      rd_cnt <= '0;
      tmr    <= '0;
    end else if (sqck_fall) begin
      rd_cnt <= rd_cnt + 1'b1;
      tmr    <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  logic [STATUS_BITS-1:0] frame_word, shadow;
  logic                   shadow_pend, hold;

  assign frame_word = pack_status(per_in, c1_in, c2_in, fok_in, gfs_in, lock_in, emph_in);
  assign hold       = (state == ST_SHIFT) && (state_nxt == ST_SHIFT);

  // While a readout is in flight the word is frozen; newer frames wait in the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_word <= '0;
      shadow      <= '0;
      shadow_pend <= 1'b0;
    end else if (hold) begin
      if (frame_stb) begin
        shadow      <= frame_word;
        shadow_pend <= 1'b1;
      end
    end else if (frame_stb) begin
      status_word <= frame_word;
      shadow_pend <= 1'b0;
    end else if (shadow_pend) begin
      status_word <= shadow;
      shadow_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cxd2545_soct_ctrl.sv
// Directed bench for cxd2545_soct_ctrl: a command vector table plus
// hand-written readout, timeout, shadowing and reset sequences.
`timescale 1ns/1ps
module tb_cxd2545_soct_ctrl;

  localparam int HP      = 4;
  localparam int TIMEOUT = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk_in, data_in, xlat_in, sqck_in, frame_stb;
  logic [7:0]  per_in;
  logic [2:0]  c1_in, c2_in;
  logic        fok_in, gfs_in, lock_in, emph_in;
  logic [17:0] status_word;
  logic        soct_load, soct_en, busy, cmd_valid, rd_timeout;
  logic [3:0]  cmd_addr;
  logic [19:0] cmd_data;

  always #5 clk = ~clk;

  cxd2545_soct_ctrl dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .data_in(data_in), .xlat_in(xlat_in),
    .sqck_in(sqck_in), .frame_stb(frame_stb), .per_in(per_in), .c1_in(c1_in),
    .c2_in(c2_in), .fok_in(fok_in), .gfs_in(gfs_in), .lock_in(lock_in),
    .emph_in(emph_in), .status_word(status_word), .soct_load(soct_load),
    .soct_en(soct_en), .busy(busy), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rd_timeout(rd_timeout)
  );

  int compared   = 0;
  int mismatched = 0;
  int valid_seen = 0;
  int load_seen  = 0;
  int tmo_seen   = 0;
  logic [17:0] word_at_load = '0;

  always @(negedge clk) begin
    if (cmd_valid) valid_seen++;
    if (soct_load) begin
      load_seen++;
      word_at_load = status_word;
    end
    if (rd_timeout) tmo_seen++;
  end

  typedef struct {
    logic [31:0] value;
    int          nbits;
    logic        exp_valid;
    logic [3:0]  exp_addr;
    logic [19:0] exp_data;
    logic        exp_en;
  } cmd_vec_t;

  cmd_vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBits(input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk_in = 1'b0;
      data_in = value[i];
      waitClk(HP);
      sclk_in = 1'b1;
      waitClk(HP);
    end
  endtask

  task automatic latchWord();
    xlat_in = 1'b1;
    waitClk(HP);
    xlat_in = 1'b0;
    waitClk(2 * HP);
  endtask

  task automatic sqckPulses(input int n);
    for (int i = 0; i < n; i++) begin
      sqck_in = 1'b0;
      waitClk(HP);
      sqck_in = 1'b1;
      waitClk(HP);
    end
  endtask

  task automatic pulseFrame(input logic [7:0] per, input logic [2:0] c1, input logic [2:0] c2,
                            input logic [3:0] flags);
    per_in = per; c1_in = c1; c2_in = c2;
    {fok_in, gfs_in, lock_in, emph_in} = flags;
    frame_stb = 1'b1;
    waitClk(1);
    frame_stb = 1'b0;
  endtask

  task automatic applyStimulus(input cmd_vec_t v);
    sendBits(v.value, v.nbits);
    latchWord();
  endtask

  // Empty xlat strobe; the resulting soct_load must show up within 5 clocks
  task automatic startReadout(input string tag);
    int base, n;
    base = load_seen;
    n    = 0;
    xlat_in = 1'b1;
    waitClk(HP);
    xlat_in = 1'b0;
    while (load_seen == base && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({tag, " load latency"}, 32'(load_seen != base && n <= 5), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " status_word"}, 32'(status_word), 32'd0);
    checkOutput({tag, " ctrl outputs"},
                32'({soct_load, soct_en, busy, cmd_valid, rd_timeout}), 32'd0);
    checkOutput({tag, " cmd_addr"}, 32'(cmd_addr), 32'd0);
    checkOutput({tag, " cmd_data"}, 32'(cmd_data), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, n;
    vecs[0] = '{32'h82,       8,  1'b1, 4'h8, 20'h00002, 1'b1};
    vecs[1] = '{32'h123,      12, 1'b0, 4'h8, 20'h00002, 1'b1};
    vecs[2] = '{32'h8000,     16, 1'b1, 4'h8, 20'h00000, 1'b0};
    vecs[3] = '{32'h3A5C,     16, 1'b1, 4'h3, 20'h00A5C, 1'b0};
    vecs[4] = '{32'h8F0F0F,   24, 1'b1, 4'h8, 20'hF0F0F, 1'b1};
    vecs[5] = '{32'h1F448D3,  26, 1'b1, 4'h7, 20'hD1234, 1'b1};
    vecs[6] = '{32'h8D,       8,  1'b1, 4'h8, 20'h0000D, 1'b0};
    vecs[7] = '{32'h0,        0,  1'b0, 4'h8, 20'h0000D, 1'b0};
    vecs[8] = '{32'h82,       8,  1'b1, 4'h8, 20'h00002, 1'b1};

    rst = 1'b1;
    sclk_in = 1'b1; data_in = 1'b0; xlat_in = 1'b0; sqck_in = 1'b1; frame_stb = 1'b0;
    per_in = '0; c1_in = '0; c2_in = '0;
    fok_in = 1'b0; gfs_in = 1'b0; lock_in = 1'b0; emph_in = 1'b0;
    waitClk(3);
    checkAllZero("in reset");
    rst = 1'b0;
    waitClk(6);
    checkAllZero("after reset");
    checkOutput("no spurious cmd_valid", 32'(valid_seen), 32'd0);

    for (int i = 0; i < 9; i++) begin
      base = valid_seen;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d cmd_valid", i), 32'(valid_seen - base), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d cmd_addr", i), 32'(cmd_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d cmd_data", i), 32'(cmd_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d soct_en", i), 32'(soct_en), 32'(vecs[i].exp_en));
    end

    // per=0x01 reversed -> 0x80, c1=5, c2=2, flags 1010 => 18'h202AA
    pulseFrame(8'h01, 3'd5, 3'd2, 4'b1010);
    startReadout("full readout");
    checkOutput("full readout word", 32'(word_at_load), 32'h202AA);
    waitClk(2);
    checkOutput("full readout busy", 32'(busy), 32'd1);
    base = tmo_seen;
    sqckPulses(18);
    waitClk(4);
    checkOutput("full readout done", 32'(busy), 32'd0);
    checkOutput("full readout no timeout", 32'(tmo_seen - base), 32'd0);

    startReadout("timeout");
    sqckPulses(10);
    base = tmo_seen;
    n    = 0;
    while (tmo_seen == base && n < TIMEOUT + 200) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("timeout fired", 32'(tmo_seen - base), 32'd1);
    checkOutput("timeout window", 32'(n >= TIMEOUT - 10 && n <= TIMEOUT + 10), 32'd1);
    waitClk(1);
    checkOutput("timeout idle", 32'({busy, soct_load}), 32'd0);

    // per=0xF0 reversed -> 0x0F, c1=3, c2=7, flags 0101 => 18'h03DF5
    startReadout("shadow");
    waitClk(2);
    pulseFrame(8'hF0, 3'd3, 3'd7, 4'b0101);
    waitClk(3);
    checkOutput("shadow held word", 32'(status_word), 32'h202AA);
    checkOutput("shadow busy", 32'(busy), 32'd1);
    sqckPulses(18);
    waitClk(4);
    checkOutput("shadow done", 32'(busy), 32'd0);
    checkOutput("shadow copied", 32'(status_word), 32'h03DF5);

    startReadout("reset mid-shift");
    sqckPulses(5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkAllZero("reset mid-shift");
    waitClk(2);
    rst = 1'b0;
    waitClk(4);
    base = load_seen;
    latchWord();
    waitClk(10);
    checkOutput("post-reset no load", 32'(load_seen - base), 32'd0);
    checkOutput("post-reset soct_en", 32'(soct_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
